// File: rtl/acq_strobe_accum_if.sv
// acq_strobe_accum_if: result handshake between the strobe accumulator and the host
interface acq_strobe_accum_if #(
  parameter int ACC_W = 28,
  parameter int CNT_W = 16
);
  logic [ACC_W-1:0] acc_data;
  logic [CNT_W-1:0] acq_cnt;
  logic [CNT_W-1:0] add_cnt;
  logic out_valid;
  logic out_ready;
  logic ovf;
  modport master (output acc_data, acq_cnt, add_cnt, out_valid, ovf, input out_ready);
  modport slave (input acc_data, acq_cnt, add_cnt, out_valid, ovf, output out_ready);
endinterface

// File: rtl/acq_strobe_accum.sv
// acq_strobe_accum: synchronises gated acquisition strobes, captures and stacks ADC samples
module acq_strobe_accum #(
  parameter int ADC_W = 12,
  parameter int ACC_W = 28,
  parameter int CNT_W = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_sys,
  input  logic rst_n,
  input  logic start,
  input  logic clk_acq,
  input  logic clk_add,
  input  logic entop,
  input  logic [ADC_W-1:0] adc_data,
  output logic busy,
  acq_strobe_accum_if.master res
);
  typedef enum logic [2:0] {IDLE, ARM, ACQ, FLUSH, OUT} state_t;
  state_t state, state_nx;
  logic [SYNC_STAGES-1:0] acq_sr, add_sr, top_sr;
  logic acq_q, add_q, top_q;
  logic acq_stb, add_stb, top_s, top_fall;
  logic proc;
  logic [ADC_W-1:0] sample_reg;
  logic signed [ACC_W:0] sum;
  logic clamp;
  logic [ACC_W-1:0] acc_nx;
  // Synchroniser chains plus one edge-detect stage per asynchronous input
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      acq_sr <= '0;
      add_sr <= '0;
      top_sr <= '0;
      acq_q <= 1'b0;
      add_q <= 1'b0;
      top_q <= 1'b0;
    end else begin
      acq_sr <= {acq_sr[SYNC_STAGES-2:0], clk_acq};
      add_sr <= {add_sr[SYNC_STAGES-2:0], clk_add};
      top_sr <= {top_sr[SYNC_STAGES-2:0], entop};
      acq_q <= acq_sr[SYNC_STAGES-1];
      add_q <= add_sr[SYNC_STAGES-1];
      top_q <= top_sr[SYNC_STAGES-1];
    end
  end
  // Edge strobes and saturating sum of the accumulator with the previously captured sample
  always_comb begin
    acq_stb = acq_sr[SYNC_STAGES-1] & ~acq_q;
    add_stb = add_sr[SYNC_STAGES-1] & ~add_q;
    top_s = top_sr[SYNC_STAGES-1];
    top_fall = ~top_s & top_q;
    sum = $signed({res.acc_data[ACC_W-1], res.acc_data}) + (ACC_W+1)'($signed(sample_reg));
    clamp = sum[ACC_W] != sum[ACC_W-1];
    acc_nx = !clamp ? sum[ACC_W-1:0] : sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
  end
  // State register
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  state_nx = start ? ARM : IDLE;
      ARM:   state_nx = top_s ? ACQ : ARM;
      ACQ:   state_nx = top_fall ? FLUSH : ACQ;
      FLUSH: state_nx = OUT;
      OUT:   state_nx = res.out_ready ? IDLE : OUT;
      default: state_nx = IDLE;
    endcase
  end
  // State-decoded outputs; strobes only count in ACQ and the single FLUSH cycle
  always_comb begin
    busy = state != IDLE;
    res.out_valid = state == OUT;
    proc = state == ACQ || state == FLUSH;
  end
  // Sample capture, accumulation and strobe counters; cleared by an accepted start
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      sample_reg <= '0;
      res.acc_data <= '0;
      res.acq_cnt <= '0;
      res.add_cnt <= '0;
      res.ovf <= 1'b0;
    end else if (state == IDLE && start) begin
      sample_reg <= '0;
      res.acc_data <= '0;
      res.acq_cnt <= '0;
      res.add_cnt <= '0;
      res.ovf <= 1'b0;
    end else if (proc) begin
      if (acq_stb) begin
        sample_reg <= adc_data;
        res.acq_cnt <= res.acq_cnt + CNT_W'(!(&res.acq_cnt));
      end
      if (add_stb) begin
        res.acc_data <= acc_nx;
        res.add_cnt <= res.add_cnt + CNT_W'(!(&res.add_cnt));
        if (clamp) res.ovf <= 1'b1;
      end
    end
  end
endmodule
